wb_stage: RTL and testbench

Writeback stage of the MIPS pipeline: accepts retiring instructions with their ALU result and PC+4, waits for load data from data memory when required, and drives the register-file write port (Wen/Waddr/Wdata) that feeds the decode stage's register file. It is the write side of the register file that decode reads. It also decodes the destination register, selects write data and flags memory timeouts.

---
 rtl/mips_pkg.sv | 30 +++
 rtl/wb_dest_decode.sv | 73 +++++++
 rtl/wb_stage.sv | 155 +++++++++++++++
 tb/tb_wb_stage.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS opcode constants and writeback-stage types.
// Imported by wb_dest_decode and wb_stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    WRITE
  } wb_state_t;

endpackage

// File: rtl/wb_dest_decode.sv
// Destination-register decode for retiring instructions.
// Flags writers, loads and links and picks rd/rt/$ra.
module wb_dest_decode
  import mips_pkg::*;
(
  input  logic [31:0] i_ins,
  output logic        o_writes,
  output logic        o_is_load,
  output logic        o_is_link,
  output logic [4:0]  o_dest
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic [4:0] w_rt;
  logic [4:0] w_rd;
  logic       w_rtype;
  logic       w_imm;
  logic       w_lw;
  logic       w_jal;
  logic       w_unused;

  assign w_op = i_ins[31:26];
  assign w_fn = i_ins[5:0];
  assign w_rt = i_ins[20:16];
  assign w_rd = i_ins[15:11];

  assign w_unused = ^{i_ins[25:21], i_ins[10:6]};

  assign w_rtype = (w_op == OP_RTYPE) &&
                   (w_fn != FUNCT_JR);
  assign w_imm   = (w_op == OP_ADDI)  ||
                   (w_op == OP_ADDIU) ||
                   (w_op == OP_SLTI)  ||
                   (w_op == OP_ANDI)  ||
                   (w_op == OP_ORI)   ||
                   (w_op == OP_XORI)  ||
                   (w_op == OP_LUI);
  assign w_lw    = (w_op == OP_LW);
  assign w_jal   = (w_op == OP_JAL);

  // pick destination and class; the four classes are disjoint
  always_comb begin
    o_writes  = 1'b0;
    o_is_load = 1'b0;
    o_is_link = 1'b0;
    o_dest    = 5'd0;
    unique case (1'b1)
      w_rtype: begin
        o_writes = 1'b1;
        o_dest   = w_rd;
      end
      w_imm: begin
        o_writes = 1'b1;
        o_dest   = w_rt;
      end
      w_lw: begin
        o_writes  = 1'b1;
        o_is_load = 1'b1;
        o_dest    = w_rt;
      end
      w_jal: begin
        o_writes  = 1'b1;
        o_is_link = 1'b1;
        o_dest    = REG_RA;
      end
      default: begin
        o_writes = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: register-file write port, load wait, timeout.
// Optional EX bypass outputs under WB_FORWARD_EN.
module wb_stage
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        In_valid,
  output logic        In_ready,
  input  logic [31:0] Ins,
  input  logic [31:0] Alu_res,
  input  logic [31:0] Pc4,
  input  logic        Mem_ack,
  input  logic [31:0] Mem_rdata,
  output logic        Wen,
  output logic [4:0]  Waddr,
  output logic [31:0] Wdata,
  output logic        Retired,
  output logic        Err
`ifdef WB_FORWARD_EN
  ,
  output logic        Fwd_valid,
  output logic [4:0]  Fwd_addr,
  output logic [31:0] Fwd_data
`endif
);

  localparam logic [7:0] CNT_LAST =
    8'(MEM_TIMEOUT - 1);

  wb_state_t   r_state;
  wb_state_t   w_nxt_state;
  logic [7:0]  r_cnt;
  logic [7:0]  w_nxt_cnt;
  logic [4:0]  r_waddr;
  logic [4:0]  w_nxt_waddr;
  logic [31:0] r_wdata;
  logic [31:0] w_nxt_wdata;
  logic        r_wen;
  logic        w_nxt_wen;
  logic        r_ret;
  logic        w_nxt_ret;
  logic        r_err;
  logic        w_nxt_err;

  logic        w_writes;
  logic        w_is_load;
  logic        w_is_link;
  logic [4:0]  w_dest;

  wb_dest_decode u_dec (
    .i_ins     (Ins),
    .o_writes  (w_writes),
    .o_is_load (w_is_load),
    .o_is_link (w_is_link),
    .o_dest    (w_dest)
  );

  assign In_ready = (r_state == IDLE);

  // next state, latched dest/data and one-cycle output pulses
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_waddr = r_waddr;
    w_nxt_wdata = r_wdata;
    w_nxt_wen   = 1'b0;
    w_nxt_ret   = 1'b0;
    w_nxt_err   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (In_valid) begin
          if (w_is_load) begin
            w_nxt_state = WAIT_MEM;
            w_nxt_cnt   = 8'd0;
            w_nxt_waddr = w_dest;
          end else if (w_writes) begin
            w_nxt_state = WRITE;
            w_nxt_waddr = w_dest;
            w_nxt_wdata = w_is_link ?
                          (Pc4 + 32'd4) : Alu_res;
            w_nxt_wen   = (w_dest != 5'd0);
            w_nxt_ret   = 1'b1;
          end else begin
            w_nxt_ret = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        if (Mem_ack) begin
          w_nxt_state = WRITE;
          w_nxt_wdata = Mem_rdata;
          w_nxt_wen   = (r_waddr != 5'd0);
          w_nxt_ret   = 1'b1;
          w_nxt_cnt   = 8'd0;
        end else if (r_cnt == CNT_LAST) begin
          w_nxt_state = IDLE;
          w_nxt_err   = 1'b1;
          w_nxt_cnt   = 8'd0;
        end else begin
          w_nxt_cnt = r_cnt + 8'd1;
        end
      end
      WRITE: begin
        w_nxt_state = IDLE;
      end
      default: begin
        w_nxt_state = IDLE;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_waddr <= 5'd0;
      r_wdata <= 32'd0;
      r_wen   <= 1'b0;
      r_ret   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_waddr <= w_nxt_waddr;
      r_wdata <= w_nxt_wdata;
      r_wen   <= w_nxt_wen;
      r_ret   <= w_nxt_ret;
      r_err   <= w_nxt_err;
    end
  end

  assign Wen     = r_wen;
  assign Waddr   = r_waddr;
  assign Wdata   = r_wdata;
  assign Retired = r_ret;
  assign Err     = r_err;

`ifdef WB_FORWARD_EN
  logic w_ack_fwd;

  assign w_ack_fwd = (r_state == WAIT_MEM) &&
                     Mem_ack;
  assign Fwd_valid = r_wen ||
                     (w_ack_fwd &&
                      (r_waddr != 5'd0));
  assign Fwd_addr  = r_waddr;
  assign Fwd_data  = w_ack_fwd ?
                     Mem_rdata : r_wdata;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage.
// Directed plan cases plus random traffic vs a cycle-level model.
module tb_wb_stage;

  localparam int T = 15;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        In_valid = 1'b0;
  logic        In_ready;
  logic [31:0] Ins = '0;
  logic [31:0] Alu_res = '0;
  logic [31:0] Pc4 = '0;
  logic        Mem_ack = 1'b0;
  logic [31:0] Mem_rdata = '0;
  logic        Wen;
  logic [4:0]  Waddr;
  logic [31:0] Wdata;
  logic        Retired;
  logic        Err;

  always #5 CLK = ~CLK;

  wb_stage #(.MEM_TIMEOUT(T)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .Ins       (Ins),
    .Alu_res   (Alu_res),
    .Pc4       (Pc4),
    .Mem_ack   (Mem_ack),
    .Mem_rdata (Mem_rdata),
    .Wen       (Wen),
    .Waddr     (Waddr),
    .Wdata     (Wdata),
    .Retired   (Retired),
    .Err       (Err)
  );

  int nvec = 0;
  int nerr = 0;
  int nchk = 0;
  int e = 0;

  // model: edge at which the stage is next free, pending load
  bit         m_wait = 1'b0;
  int         m_free = 0;
  int         m_ws = 0;
  int         m_k = 0;
  logic [4:0] m_dest = '0;

  // expected outputs for the cycle after the latest edge
  bit          live = 1'b0;
  bit          x_ready = 1'b1;
  bit          x_wen = 1'b0;
  bit          x_ret = 1'b0;
  bit          x_err = 1'b0;
  logic [4:0]  x_addr = '0;
  logic [31:0] x_data = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)",
               nm, act, exp, e);
    end
  endtask

  // kind: 0 none, 1 alu write, 2 load, 3 link
  function automatic void ref_dec(input logic [31:0] ins,
                                  output int kind,
                                  output logic [4:0] d);
    int op;
    op = int'(ins[31:26]);
    kind = 0;
    d = 5'd0;
    if (op == 0) begin
      kind = (ins[5:0] == 6'h08) ? 0 : 1;
      d = ins[15:11];
    end else if (op == 8 || op == 9 || op == 10 ||
                 op == 12 || op == 13 || op == 14 ||
                 op == 15) begin
      kind = 1;
      d = ins[20:16];
    end else if (op == 'h23) begin
      kind = 2;
      d = ins[20:16];
    end else if (op == 3) begin
      kind = 3;
      d = 5'd31;
    end
  endfunction

  // drive one edge's inputs and advance the model across it
  task automatic step(input bit v,
                      input logic [31:0] ins,
                      input logic [31:0] alu,
                      input logic [31:0] pc4,
                      input bit ack,
                      input logic [31:0] rd);
    int kind;
    logic [4:0] d;
    @(negedge CLK);
    #1;
    In_valid = v;
    Ins = ins;
    Alu_res = alu;
    Pc4 = pc4;
    Mem_ack = ack;
    Mem_rdata = rd;
    e++;
    nvec++;
    x_wen = 1'b0;
    x_ret = 1'b0;
    x_err = 1'b0;
    if (m_wait) begin
      if (ack) begin
        x_wen = (m_dest != 5'd0);
        x_ret = 1'b1;
        x_addr = m_dest;
        x_data = rd;
        m_wait = 1'b0;
        m_free = e + 2;
      end else if (e == m_ws + T) begin
        x_err = 1'b1;
        m_wait = 1'b0;
        m_free = e + 1;
      end
    end else if (v && e >= m_free) begin
      ref_dec(ins, kind, d);
      if (kind == 0) begin
        x_ret = 1'b1;
        m_free = e + 1;
      end else if (kind == 2) begin
        m_wait = 1'b1;
        m_ws = e;
        m_dest = d;
        case ($urandom_range(0, 3))
          0: m_k = 0;
          1: m_k = T;
          default: m_k = $urandom_range(1, T);
        endcase
      end else begin
        x_wen = (d != 5'd0);
        x_ret = 1'b1;
        x_addr = d;
        x_data = (kind == 3) ? pc4 + 32'd4 : alu;
        m_free = e + 2;
      end
    end
    x_ready = !m_wait && (e + 1 >= m_free);
    live = 1'b1;
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic settle();
    @(posedge CLK);
    #1;
  endtask

  // compare DUT against the model every cycle
  always @(negedge CLK) begin
    if (live) begin
      chk("In_ready", 32'(In_ready), 32'(x_ready));
      chk("Wen", 32'(Wen), 32'(x_wen));
      chk("Retired", 32'(Retired), 32'(x_ret));
      chk("Err", 32'(Err), 32'(x_err));
      if (x_wen) begin
        chk("Waddr", 32'(Waddr), 32'(x_addr));
        chk("Wdata", Wdata, x_data);
      end
    end
  end

  logic [5:0] ops [15];

  function automatic logic [31:0] gen_ins();
    logic [31:0] w;
    logic [5:0] op;
    op = ops[$urandom_range(0, 14)];
    if ($urandom_range(0, 9) == 0)
      op = 6'($urandom);
    w = $urandom;
    w[31:26] = op;
    if (op == 6'h00 && $urandom_range(0, 3) == 0)
      w[5:0] = 6'h08;
    if ($urandom_range(0, 7) == 0) w[15:11] = 5'd0;
    if ($urandom_range(0, 7) == 0) w[20:16] = 5'd0;
    return w;
  endfunction

  initial begin
    bit ack;
    logic [31:0] pc;
    ops = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C,
            6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B,
            6'h04, 6'h05, 6'h02, 6'h03, 6'h23};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst In_ready", 32'(In_ready), 32'd1);
    chk("rst Wen", 32'(Wen), 32'd0);
    chk("rst Waddr", 32'(Waddr), 32'd0);
    chk("rst Wdata", Wdata, 32'd0);
    chk("rst Retired", 32'(Retired), 32'd0);
    chk("rst Err", 32'(Err), 32'd0);
    RST = 1'b1;

    // ori $1,$0,5
    step(1, 32'h34010005, 32'd5, 32'd0, 0, 32'd0);
    settle();
    chk("ori Wen", 32'(Wen), 32'd1);
    chk("ori Waddr", 32'(Waddr), 32'd1);
    chk("ori Wdata", Wdata, 32'd5);
    chk("ori Retired", 32'(Retired), 32'd1);
    idle();

    // add $3,$1,$2
    step(1, 32'h00221820, 32'd8, 32'd0, 0, 32'd0);
    settle();
    chk("add Wen", 32'(Wen), 32'd1);
    chk("add Waddr", 32'(Waddr), 32'd3);
    chk("add Wdata", Wdata, 32'd8);
    chk("add In_ready", 32'(In_ready), 32'd0);
    idle();

    // lw $2,4($1), ack on third wait edge
    step(1, 32'h8C220004, 32'd0, 32'd0, 0, 32'd0);
    idle();
    idle();
    step(0, 32'd0, 32'd0, 32'd0, 1, 32'h12345678);
    settle();
    chk("lw Wen", 32'(Wen), 32'd1);
    chk("lw Waddr", 32'(Waddr), 32'd2);
    chk("lw Wdata", Wdata, 32'h12345678);
    idle();

    // sw, beq, j back to back
    step(1, 32'hAC220008, 32'd0, 32'd0, 1, 32'd7);
    settle();
    chk("sw Retired", 32'(Retired), 32'd1);
    chk("sw Wen", 32'(Wen), 32'd0);
    step(1, 32'h10220010, 32'd0, 32'd0, 0, 32'd0);
    settle();
    chk("beq Retired", 32'(Retired), 32'd1);
    chk("beq Wen", 32'(Wen), 32'd0);
    step(1, 32'h08000400, 32'd0, 32'd0, 0, 32'd0);
    settle();
    chk("j Retired", 32'(Retired), 32'd1);
    chk("j Wen", 32'(Wen), 32'd0);

    // jal
    step(1, 32'h0C000400, 32'd0, 32'h00400008, 0, 32'd0);
    settle();
    chk("jal Waddr", 32'(Waddr), 32'd31);
    chk("jal Wdata", Wdata, 32'h0040000C);
    idle();

    // load timeout
    step(1, 32'h8C220004, 32'd0, 32'd0, 0, 32'd0);
    for (int i = 0; i < T - 1; i++) idle();
    settle();
    chk("to Err early", 32'(Err), 32'd0);
    idle();
    settle();
    chk("to Err", 32'(Err), 32'd1);
    chk("to Wen", 32'(Wen), 32'd0);
    chk("to Retired", 32'(Retired), 32'd0);
    chk("to In_ready", 32'(In_ready), 32'd1);
    idle();

    // reset asserted in WAIT_MEM
    step(1, 32'h8C220004, 32'd0, 32'd0, 0, 32'd0);
    idle();
    settle();
    live = 1'b0;
    RST = 1'b0;
    #1;
    chk("mr In_ready", 32'(In_ready), 32'd1);
    chk("mr Wen", 32'(Wen), 32'd0);
    chk("mr Waddr", 32'(Waddr), 32'd0);
    chk("mr Wdata", Wdata, 32'd0);
    chk("mr Retired", 32'(Retired), 32'd0);
    chk("mr Err", 32'(Err), 32'd0);
    @(negedge CLK);
    Mem_ack = 1'b1;
    Mem_rdata = 32'hDEADBEEF;
    @(negedge CLK);
    chk("mr hold Wen", 32'(Wen), 32'd0);
    RST = 1'b1;
    m_wait = 1'b0;
    m_free = 0;
    step(0, 32'd0, 32'd0, 32'd0, 1, 32'hDEADBEEF);
    settle();
    chk("mr ack Wen", 32'(Wen), 32'd0);
    chk("mr ack Retired", 32'(Retired), 32'd0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if (m_wait)
        ack = (m_k != 0) && (e + 1 == m_ws + m_k);
      else
        ack = ($urandom_range(0, 3) == 0);
      pc = ($urandom_range(0, 15) == 0) ?
           32'hFFFFFFFC : $urandom;
      step($urandom_range(0, 9) < 7, gen_ins(),
           $urandom, pc, ack, $urandom);
    end
    @(negedge CLK);
    #1;
    live = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
